// File: rtl/spi_slave_regif.sv
// Register-access controller on the rx/tx side of spi_slave: the first word of each frame
// is a command (rw + start address), the following words are writes or prefetched reads.
//   state | meaning
//   IDLE  | deselected, or waiting for rx_ss high after reset
//   CMD   | shifting in the command word
//   WR    | each data word becomes one reg_wr
//   RD    | each tx_load stages the next prefetched read
module spi_slave_regif #(
  parameter int                 WIDTH       = 8,
  parameter int                 ADDR_WIDTH  = 7,
  parameter int                 RD_LATENCY  = 1,
  parameter logic [WIDTH-1:0]   STATUS_WORD = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_ss,
  input  logic [WIDTH-1:0]              rx_data,
  input  logic [$clog2(WIDTH-1)-1:0]    rx_bitcnt,
  input  logic                          rx_valid,
  output logic [WIDTH-1:0]              tx_data,
  input  logic                          tx_load,
  output logic [ADDR_WIDTH-1:0]         reg_addr,
  output logic [WIDTH-1:0]              reg_wdata,
  output logic                          reg_wr,
  output logic                          reg_rd,
  input  logic [WIDTH-1:0]              reg_rdata,
  output logic                          busy,
  output logic                          err_overrun
);

  localparam int BCW = $clog2(WIDTH-1);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t                state, state_nxt;
  logic                  armed;
  logic                  word_done;
  logic                  rd_pending;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  wr_set, rd_set, addr_load, addr_inc, ovr_set;

  assign word_done  = rx_valid && (rx_bitcnt == BCW'(WIDTH-1));
  assign rd_pending = reg_rd || (|rd_pipe);

  // armed blocks a frame that was already running when reset released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rx_ss) armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rx_ss) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (armed) state_nxt = CMD;
        CMD:     if (word_done) state_nxt = rx_data[WIDTH-1] ? RD : WR;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    wr_set    = 1'b0;
    rd_set    = 1'b0;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    ovr_set   = 1'b0;
    if (!rx_ss) begin
      case (state)
        CMD: if (word_done) begin
          addr_load = 1'b1;
          rd_set    = rx_data[WIDTH-1];
        end
        WR: begin
          wr_set   = word_done;
          addr_inc = reg_wr;
        end
        RD: if (tx_load) begin
          rd_set   = 1'b1;
          addr_inc = 1'b1;
          ovr_set  = rd_pending;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data     <= STATUS_WORD;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      err_overrun <= 1'b0;
      rd_pipe     <= '0;
    end else begin
      reg_wr      <= wr_set;
      reg_rd      <= rd_set;
      err_overrun <= ovr_set;
      if (wr_set) reg_wdata <= rx_data;
      if (addr_load)
        reg_addr <= rx_data[ADDR_WIDTH-1:0];
      else if (addr_inc)
        reg_addr <= reg_addr + ADDR_WIDTH'(1);
      // the pipe tracks reads in flight; deselect throws away whatever is pending
      if (rx_ss) begin
        rd_pipe <= '0;
      end else begin
        rd_pipe[0] <= reg_rd;
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
      if (rx_ss || state == IDLE)
        tx_data <= STATUS_WORD;
      else if (rd_pipe[RD_LATENCY-1])
        tx_data <= reg_rdata;
    end
  end

endmodule
